multi_clk_div: RTL

MULTI_CLK_DIV -- requirements
Module: multi_clk_div

---
 rtl/multi_clk_div.sv | 119 +++++++++++
 1 files changed

// File: rtl/multi_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : multi_clk_div
// Summary  : NUM_CH independent 50%-duty clock dividers, each with a
//            shadowed half-period that takes effect only on a phase boundary.
//            Optional macro MULTI_CLK_DIV_SYNC_EN adds a sync_req input that
//            realigns all channels.
// Revision : 1.0 - initial release
// ============================================================================
module multi_clk_div #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 27,
  parameter int DEF_HALF = 50000000,
  parameter int CH_W     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
`ifdef MULTI_CLK_DIV_SYNC_EN
  input  logic              sync_req,
`endif
  output logic              div_ack,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] c_def_half = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  logic             w_wr_ok;
  logic [CNT_W-1:0] w_wval;
  logic             r_ack;

  assign w_wr_ok = div_wr && (32'(div_ch) < NUM_CH);
  // A zero half-period would never reach terminal; clamp to 1.
  assign w_wval  = (div_val == '0) ? c_one : div_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack <= 1'b0;
`ifdef MULTI_CLK_DIV_SYNC_EN
    end else if (sync_req) begin
      r_ack <= 1'b0;
`endif
    end else begin
      r_ack <= w_wr_ok;
    end
  end

  assign div_ack = r_ack;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_s;
    logic             r_p;
    logic [CNT_W-1:0] r_c;
    logic             r_clk;
    logic             r_tick;
    logic             w_term;
    logic             w_hit;

    assign w_term = (r_c == (r_h - c_one));
    assign w_hit  = w_wr_ok && (div_ch == CH_W'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        r_h    <= c_def_half;
        r_s    <= c_def_half;
        r_p    <= 1'b0;
        r_c    <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
`ifdef MULTI_CLK_DIV_SYNC_EN
      end else if (sync_req) begin
        r_c    <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
        if (r_p) begin
          r_h <= r_s;
          r_p <= 1'b0;
        end
`endif
      end else begin
        r_tick <= 1'b0;
        if (en[i]) begin
          if (w_term) begin
            r_c    <= '0;
            r_clk  <= ~r_clk;
            r_tick <= ~r_clk;
            if (r_p) begin
              r_h <= r_s;
              r_p <= 1'b0;
            end
          end else begin
            r_c <= r_c + c_one;
          end
        end else if (r_p) begin
          // Idle channel: no phase to protect, apply immediately.
          r_h <= r_s;
          r_p <= 1'b0;
          r_c <= '0;
        end
        // Placed last so a coincident write re-arms the shadow.
        if (w_hit) begin
          r_s <= w_wval;
          r_p <= 1'b1;
        end
      end
    end

    assign clk_out[i] = r_clk;
    assign tick[i]    = r_tick;
  end

endmodule
`default_nettype wire
